// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin scheduler feeding a UART byte transmitter
module uart_tx_sched #(
    parameter int GAP_CYCLES = 5208,
    parameter int TIMEOUT    = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] tx_byte,
    output logic       tx_en,
    input  logic       tx_done,
    output logic       grant_id,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam logic        HAS_GAP   = (GAP_CYCLES > 0);

    state_t      state_q, state_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_en_q, tx_en_d;
    logic        grant_id_q, grant_id_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        timeout_err_q, timeout_err_d;
    logic        tx_done_q, tx_done_d;
    logic [23:0] wdog_q, wdog_d;
    logic [15:0] gap_q, gap_d;

    logic done_rise;
    logic wdog_expired;
    logic pick1;

    // Only a fresh rising edge of tx_done ends a frame; a level left over
    // from the previous frame must not.
    assign done_rise    = tx_done & ~tx_done_q;
    assign wdog_expired = (wdog_q == WDOG_LAST);
    // On a tie the requester not served last wins.
    assign pick1        = req1 & (~req0 | ~grant_id_q);

    always_comb begin
        state_d       = state_q;
        tx_byte_d     = tx_byte_q;
        tx_en_d       = tx_en_q;
        grant_id_d    = grant_id_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        timeout_err_d = 1'b0;
        tx_done_d     = tx_done;
        wdog_d        = wdog_q;
        gap_d         = gap_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    tx_byte_d  = pick1 ? data1 : data0;
                    grant_id_d = pick1;
                    ack0_d     = ~pick1;
                    ack1_d     = pick1;
                    tx_en_d    = 1'b1;
                    wdog_d     = 24'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (done_rise || wdog_expired) begin
                    tx_en_d       = 1'b0;
                    timeout_err_d = ~done_rise;
                    if (HAS_GAP) begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end
            GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_byte_q     <= 8'h00;
            tx_en_q       <= 1'b0;
            grant_id_q    <= 1'b1;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tx_done_q     <= 1'b0;
            wdog_q        <= 24'd0;
            gap_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            tx_byte_q     <= tx_byte_d;
            tx_en_q       <= tx_en_d;
            grant_id_q    <= grant_id_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            timeout_err_q <= timeout_err_d;
            tx_done_q     <= tx_done_d;
            wdog_q        <= wdog_d;
            gap_q         <= gap_d;
        end
    end

    assign tx_byte     = tx_byte_q;
    assign tx_en       = tx_en_q;
    assign grant_id    = grant_id_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester round-robin scheduler in front of the UART byte transmitter. It accepts bytes from two independent producers over a req/ack handshake and loads one byte at a time into the transmitter. It holds the transmitter enable for the whole frame, detects frame completion, and enforces an idle gap between frames. A watchdog aborts any frame that never reports completion.

## Interface
- GAP_CYCLES, 5208: idle clocks between the end of one frame and the next grant; one 9600-baud bit time at 50 MHz. Range 0..65535.
- TIMEOUT, 1000000: maximum clocks in SEND before the frame is aborted. Range 2..2^24-1.
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 has a byte pending (level)
- data0  in  8  requester 0 byte; stable while req0=1
- ack0  out  1  one-cycle pulse: data0 captured
- req1 / data1 / ack1: same as requester 0, for requester 1
- tx_byte  out  8  byte to transmitter
- tx_en  out  1  transmitter enable; high for the whole frame
- tx_done  in  1  transmitter done flag; level, may stay high after a frame
- grant_id  out  1  requester currently or last served
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a frame

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE, neither req asserted: stay in IDLE.
- IDLE, one req asserted: grant that requester.
- IDLE, both req asserted: grant the requester that is not grant_id, so service alternates.
- After reset grant_id=1, so requester 0 wins the first tie.
- On grant, all in one edge:
  - tx_byte <= dataN
  - grant_id <= N
  - ackN pulses for exactly one cycle
  - tx_en <= 1
  - watchdog cleared
  - state <= SEND
- tx_done_q is a register that samples tx_done every cycle.
- done_rise = tx_done & ~tx_done_q. Only done_rise counts as completion.
  - A tx_done level still high from the previous frame is ignored.
- SEND, done_rise: tx_en <= 0. Then:
  - GAP_CYCLES>0: load gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP_CYCLES=0: go to IDLE.
- SEND, no done_rise: the watchdog increments each cycle.
- SEND, watchdog = TIMEOUT-1 with no done_rise: tx_en <= 0, timeout_err pulses, then same GAP/IDLE choice as completion.
  - If done_rise and watchdog expiry happen in the same cycle, completion wins and timeout_err stays 0.
- GAP: the gap counter decrements each cycle. At 0, go to IDLE.
  - Requests are not sampled in GAP.
- tx_byte holds its value outside SEND. The transmitter may sample it at any bit slot.
- A requester that keeps reqN high after ackN is offering its next byte; it must present that byte by the cycle after ack.
- Dropping reqN before ack withdraws the request with no side effects.
- Watchdog counter: 24 bits. Gap counter: 16 bits. Neither wraps; both are reloaded before use.

## Timing
- Reset values:
  - tx_en=0, tx_byte=8'h00
  - ack0=ack1=0, timeout_err=0
  - busy=0, grant_id=1
  - state IDLE, tx_done_q=0
  - counters 0
- Grant latency: req seen in IDLE at edge k; ackN, tx_en and tx_byte are valid after edge k+1, with no combinational path from req to ack.
- Release latency: done_rise at edge k; tx_en=0 after edge k+1.
- Frame-to-frame minimum: GAP_CYCLES + 1 clocks with tx_en=0 between frames.
- Reset mid-frame: all outputs take reset values immediately, and any pending ack is lost.
  - The requester re-presents its byte after reset.
- busy rises with tx_en and falls on the cycle the FSM enters IDLE.

## Test plan
- Single byte: req0=1, data0=8'hA5, transmitter model raises tx_done after 100 clocks -> ack0 is one pulse, tx_byte=8'hA5, tx_en high until one clock after the tx_done rise, then GAP_CYCLES idle clocks.
- Contention: req0 and req1 held high with 3 bytes each -> grants alternate 0,1,0,1,0,1 and each ack matches its byte order.
- Stale done: tx_done held high from the previous frame at the next grant -> tx_en stays high until tx_done falls and rises again.
- Watchdog: TIMEOUT=50, tx_done never rises -> tx_en drops after 50 SEND clocks, timeout_err pulses once, the next grant follows after the gap.
- Simultaneous events: done_rise on the watchdog-expiry cycle -> timeout_err=0, normal completion.
- Reset mid-frame: rst_n low during SEND -> tx_en=0 and busy=0 asynchronously; after release with req1=1, requester 1 is granted within 2 clocks.
